lru_fill_ctrl: RTL
==================

LRU_FILL_CTRL -- requirements
Module: lru_fill_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 8: lookup tag width in bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: lookup request present.
REQ-005 SHALL have port req_tag, input, TAG_W: lookup tag.
REQ-006 SHALL have port req_ready, output, 1: request accepted when req_valid && req_ready.
REQ-007 SHALL have port flush, input, 1: invalidate all four entries.
REQ-008 SHALL have port resp_valid, output, 1: one-cycle response strobe.
REQ-009 SHALL have port resp_hit, output, 1: 1 = hit, 0 = miss then fill.
REQ-010 SHALL have port resp_way, output, 2: way holding the tag.
REQ-011 SHALL have port fill_valid, output, 1: fill request to memory.
REQ-012 SHALL have port fill_tag, output, TAG_W: tag being filled.
REQ-013 SHALL have port fill_ready, input, 1: memory accepts the fill request.
REQ-014 SHALL have port fill_done, input, 1: fill data returned.
REQ-015 SHALL have port lru_victim_i, input, 2: least-recently-used way from the LRU list.
REQ-016 SHALL have port lru_index_o, output, 2: way index presented to the LRU list.
REQ-017 SHALL have port lru_access, output, 1: pulse that promotes lru_index_o and ages the other ways.
REQ-018 SHALL have port lru_update, output, 1: pulse that zeroes the age of lru_index_o only.

Function
REQ-019 SHALL hold 4 entries, each a TAG_W tag plus a valid bit.
REQ-020 SHALL implement FSM states IDLE, LOOKUP, FILL_REQ, FILL_WAIT, RESP.
REQ-021 SHALL drive req_ready = 1 only in IDLE with flush = 0.
REQ-022 SHALL, in IDLE, latch req_tag on acceptance and go to LOOKUP.
REQ-023 SHALL, in IDLE with flush = 1, clear all valid bits that cycle and stay in IDLE; flush has priority over req_valid.
REQ-024 SHALL ignore flush in every state other than IDLE.
REQ-025 SHALL, in LOOKUP, compare the latched tag against all valid entries; tags in invalid entries never match.
REQ-026 SHALL, on a hit in LOOKUP, pulse lru_access for one cycle with lru_index_o = hit way, latch resp_hit = 1 and resp_way = hit way, and go to RESP.
REQ-027 SHALL, on a miss in LOOKUP, select the lowest-numbered invalid way as victim, or lru_victim_i when all four ways are valid, latch the victim, and go to FILL_REQ.
REQ-028 SHALL, in FILL_REQ, hold fill_valid = 1 with fill_tag = latched tag until fill_ready = 1, then go to FILL_WAIT.
REQ-029 SHALL keep fill_valid and fill_tag stable while fill_ready = 0.
REQ-030 SHALL ignore fill_done outside FILL_WAIT.
REQ-031 SHALL, in FILL_WAIT on fill_done = 1, write the tag into the victim entry, set its valid bit, pulse lru_update with lru_index_o = victim, latch resp_hit = 0 and resp_way = victim, and go to RESP.
REQ-032 SHALL, in RESP, drive resp_valid = 1 for exactly one cycle and then return to IDLE.
REQ-033 SHALL drive lru_index_o = 0 whenever lru_access and lru_update are both 0.
REQ-034 SHALL never assert lru_access and lru_update in the same cycle.
REQ-035 SHALL give hit latency as: request accepted at edge N, resp_valid high in cycle N+2.
REQ-036 SHALL give miss latency as: resp_valid high in the cycle after the fill_done cycle.
REQ-037 SHALL drive resp_hit and resp_way only when resp_valid = 1; both are 0 otherwise.

Reset
REQ-038 SHALL, on rst = 0 and regardless of clk, enter IDLE, clear all valid bits and tags, and drive every output to 0 except req_ready.
REQ-039 SHALL drive req_ready = 1 after reset release.
REQ-040 SHALL, on reset during FILL_REQ or FILL_WAIT, abort the fill: no entry is written and no lru pulse is issued.

Verification
REQ-041 SHALL pass: after reset, request tag 0x11 -> miss; fill_valid with fill_tag = 0x11; with fill_ready = 1 then fill_done = 1, lru_update pulses with index 0 and the response is resp_hit = 0, resp_way = 0.
REQ-042 SHALL pass: fill tags 0x11, 0x22, 0x33, 0x44, then request 0x33 -> lru_access with index 2 in cycle N+1, then resp_valid in cycle N+2 with resp_hit = 1, resp_way = 2.
REQ-043 SHALL pass: all four ways valid, lru_victim_i = 3, request 0x55 -> victim 3; after the fill, request 0x44 -> miss and request 0x55 -> hit way 3.
REQ-044 SHALL pass: fill_ready held 0 for 5 cycles -> fill_valid and fill_tag stable for all 5 cycles, and no response is issued.
REQ-045 SHALL pass: flush and req_valid asserted together in IDLE -> req_ready = 0 and all entries invalid; the next request for 0x11 misses to way 0.
REQ-046 SHALL pass: rst asserted in FILL_WAIT -> all outputs 0 immediately, no entry written, and the next request misses to way 0.

Source files
------------

// File: rtl/lru_fill_ctrl.sv
// Four-entry fully associative tag lookup with miss fill sequencing.
// Replacement on a full set follows the external LRU list's victim; hits promote, fills zero the age.
module lru_fill_ctrl #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_ready,
    input  logic             flush,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [1:0]       resp_way,
    output logic             fill_valid,
    output logic [TAG_W-1:0] fill_tag,
    input  logic             fill_ready,
    input  logic             fill_done,
    input  logic [1:0]       lru_victim_i,
    output logic [1:0]       lru_index_o,
    output logic             lru_access,
    output logic             lru_update
);

    // state     | meaning
    // IDLE      | waiting for a request; flush clears all entries here
    // LOOKUP    | compare latched tag against valid entries
    // FILL_REQ  | miss: present fill request until memory accepts
    // FILL_WAIT | waiting for fill data; install tag on fill_done
    // RESP      | one-cycle response strobe
    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL_WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [TAG_W-1:0] tag_mem [4];
    logic [3:0]       valid;
    logic [TAG_W-1:0] tag_q;
    logic [1:0]       victim_q;
    logic             hit_q;
    logic [1:0]       way_q;

    logic [3:0] match;
    logic       hit_any;
    logic [1:0] hit_way;
    logic [1:0] victim_sel;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            match[i] = valid[i] && (tag_mem[i] == tag_q);
        end
    end

    // Lowest-numbered way wins both for hits and for free slots.
    always_comb begin
        hit_any    = 1'b0;
        hit_way    = 2'd0;
        victim_sel = lru_victim_i;
        for (int i = 3; i >= 0; i--) begin
            if (match[i]) begin
                hit_any = 1'b1;
                hit_way = 2'(i);
            end
            if (!valid[i]) begin
                victim_sel = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        fill_valid  = 1'b0;
        lru_access  = 1'b0;
        lru_update  = 1'b0;
        lru_index_o = 2'd0;
        resp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !flush;
                if (!flush && req_valid) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    lru_access  = 1'b1;
                    lru_index_o = hit_way;
                    state_nxt   = RESP;
                end else begin
                    state_nxt = FILL_REQ;
                end
            end
            FILL_REQ: begin
                fill_valid = 1'b1;
                if (fill_ready) begin
                    state_nxt = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (fill_done) begin
                    lru_update  = 1'b1;
                    lru_index_o = victim_q;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign fill_tag = fill_valid ? tag_q : '0;
    assign resp_hit = resp_valid & hit_q;
    assign resp_way = resp_valid ? way_q : 2'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                tag_mem[i] <= '0;
            end
            valid    <= 4'd0;
            tag_q    <= '0;
            victim_q <= 2'd0;
            hit_q    <= 1'b0;
            way_q    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= 4'd0;
                    end else if (req_valid) begin
                        tag_q <= req_tag;
                    end
                end
                LOOKUP: begin
                    if (hit_any) begin
                        hit_q <= 1'b1;
                        way_q <= hit_way;
                    end else begin
                        victim_q <= victim_sel;
                    end
                end
                FILL_WAIT: begin
                    if (fill_done) begin
                        tag_mem[victim_q] <= tag_q;
                        valid[victim_q]   <= 1'b1;
                        hit_q             <= 1'b0;
                        way_q             <= victim_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
